// File: rtl/fft_pkg.sv
// Shared constants, state type, twiddle constants and address helper for the 8-point
// radix-2 decimation-in-time FFT.
package fft_pkg;

  localparam int unsigned N         = 8;
  localparam int unsigned DW        = 16;
  localparam int unsigned AW        = $clog2(N);
  localparam int unsigned NumStages = AW;
  localparam int unsigned NumBfly   = NumStages * N / 2;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StUnload
  } state_e;

  // Q1.15 twiddles W8^1 and W8^3. W8^0 and W8^2 are applied exactly, without multipliers.
  localparam logic signed [DW-1:0] Tw1Re = 16'sd23170;
  localparam logic signed [DW-1:0] Tw1Im = -16'sd23170;
  localparam logic signed [DW-1:0] Tw3Re = -16'sd23170;
  localparam logic signed [DW-1:0] Tw3Im = -16'sd23170;

  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int unsigned i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 complex butterfly: a' = (a + W*b) >>> 1, b' = (a - W*b) >>> 1.
module fft_butterfly
  import fft_pkg::*;
(
  input  logic [2*DW-1:0] a_i,
  input  logic [2*DW-1:0] b_i,
  input  logic [1:0]      tw_i,
  output logic [2*DW-1:0] a_o,
  output logic [2*DW-1:0] b_o
);

  // |W*b| reaches ~1.41 * 2^15 for W^1/W^3, so the sum needs two guard bits to stay exact.
  localparam int unsigned IW = DW + 2;
  localparam int unsigned PW = 2 * DW + 2;

  logic signed [DW-1:0] ar, ai, br, bi;
  logic signed [DW-1:0] cr, ci;
  logic signed [PW-1:0] pr, pi;
  logic signed [IW-1:0] wr, wi, sr, si, dr, di;
  logic                 unused_bits;

  always_comb begin
    ar = a_i[2*DW-1:DW];
    ai = a_i[DW-1:0];
    br = b_i[2*DW-1:DW];
    bi = b_i[DW-1:0];

    if (tw_i[1]) begin
      cr = Tw3Re;
      ci = Tw3Im;
    end else begin
      cr = Tw1Re;
      ci = Tw1Im;
    end
    pr = PW'(cr) * PW'(br) - PW'(ci) * PW'(bi);
    pi = PW'(cr) * PW'(bi) + PW'(ci) * PW'(br);

    unique case (tw_i)
      2'd0: begin
        wr = IW'(br);
        wi = IW'(bi);
      end
      2'd2: begin
        wr = IW'(bi);
        wi = -IW'(br);
      end
      default: begin
        wr = IW'(pr >>> 15);
        wi = IW'(pi >>> 15);
      end
    endcase

    sr = IW'(ar) + wr;
    si = IW'(ai) + wi;
    dr = IW'(ar) - wr;
    di = IW'(ai) - wi;

    a_o = {sr[DW:1], si[DW:1]};
    b_o = {dr[DW:1], di[DW:1]};
  end

  assign unused_bits = ^{sr[IW-1], sr[0], si[IW-1], si[0], dr[IW-1], dr[0], di[IW-1], di[0],
                         pr[PW-1:IW+15], pr[14:0], pi[PW-1:IW+15], pi[14:0]};

endmodule

// File: rtl/fft_computer.sv
// 8-point forward FFT: loads a frame into a bit-reversed register file, runs 12 in-place
// butterflies (one per cycle), then streams the bins out in natural order.
module fft_computer #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_data_valid,
  input  logic [2*DW-1:0] i_data,
  output logic            o_data_ready,
  output logic            o_data_valid,
  output logic [2*DW-1:0] o_data,
  input  logic            i_data_ready
);

  localparam int unsigned AW       = fft_pkg::AW;
  localparam int unsigned BfW      = $clog2(fft_pkg::NumBfly);
  localparam logic [BfW-1:0] LastBfly = BfW'(fft_pkg::NumBfly - 1);
  localparam logic [AW-1:0]  LastIdx  = AW'(N - 1);

  fft_pkg::state_e state_q, state_d;
  logic [AW-1:0]   load_cnt_q, load_cnt_d;
  logic [BfW-1:0]  bf_q, bf_d;
  logic [AW-1:0]   bin_q, bin_d;
  logic            rdy_q, rdy_d;
  logic [2*DW-1:0] mem_q [N];
  logic [2*DW-1:0] mem_d [N];

  logic [1:0]      stage, pos;
  logic [AW-1:0]   addr_a, addr_b;
  logic [1:0]      tw;
  logic [2*DW-1:0] bf_a, bf_b;

  // In-place DIT addressing: the pair spacing doubles every stage.
  always_comb begin
    stage = bf_q[BfW-1:2];
    pos   = bf_q[1:0];
    case (stage)
      2'd0: begin
        addr_a = {pos, 1'b0};
        addr_b = {pos, 1'b1};
        tw     = 2'd0;
      end
      2'd1: begin
        addr_a = {pos[1], 1'b0, pos[0]};
        addr_b = {pos[1], 1'b1, pos[0]};
        tw     = {pos[0], 1'b0};
      end
      default: begin
        addr_a = {1'b0, pos};
        addr_b = {1'b1, pos};
        tw     = pos;
      end
    endcase
  end

  fft_butterfly u_butterfly (
    .a_i  (mem_q[addr_a]),
    .b_i  (mem_q[addr_b]),
    .tw_i (tw),
    .a_o  (bf_a),
    .b_o  (bf_b)
  );

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    bf_d       = bf_q;
    bin_d      = bin_q;
    mem_d      = mem_q;
    unique case (state_q)
      fft_pkg::StLoad: begin
        if (i_data_valid && rdy_q) begin
          mem_d[fft_pkg::bit_rev(load_cnt_q)] = i_data;
          load_cnt_d = load_cnt_q + AW'(1);
          if (load_cnt_q == LastIdx) state_d = fft_pkg::StCompute;
        end
      end
      fft_pkg::StCompute: begin
        mem_d[addr_a] = bf_a;
        mem_d[addr_b] = bf_b;
        bf_d = bf_q + BfW'(1);
        if (bf_q == LastBfly) begin
          bf_d    = '0;
          state_d = fft_pkg::StUnload;
        end
      end
      fft_pkg::StUnload: begin
        if (i_data_ready) begin
          bin_d = bin_q + AW'(1);
          if (bin_q == LastIdx) state_d = fft_pkg::StLoad;
        end
      end
      default: state_d = fft_pkg::StLoad;
    endcase
    // Registered so ready stays low while reset is held and rises on the first edge after.
    rdy_d = (state_d == fft_pkg::StLoad);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= fft_pkg::StLoad;
      load_cnt_q <= '0;
      bf_q       <= '0;
      bin_q      <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      bf_q       <= bf_d;
      bin_q      <= bin_d;
      rdy_q      <= rdy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_data_ready = rdy_q;
  assign o_data_valid = (state_q == fft_pkg::StUnload);
  assign o_data       = o_data_valid ? mem_q[bin_q] : '0;

endmodule

// File: tb/tb_fft_computer.sv
// Self-checking bench for fft_computer: directed spectra, random frames against a fixed-point
// DFT model, backpressure, mid-frame resets and a continuous stream.
module tb_fft_computer;

  typedef logic [31:0] frame_t [8];

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic        o_data_ready;
  logic        o_data_valid;
  logic [31:0] o_data;
  logic        i_data_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  fft_computer #(
    .N  (8),
    .DW (16)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_data_ready (o_data_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .i_data_ready (i_data_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  function automatic int s16(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return int'(t);
  endfunction

  // Textbook iterative radix-2 DIT with a halving at every stage and Q1.15 twiddles.
  function automatic void ref_fft(input frame_t x, output frame_t y);
    int re[8];
    int im[8];
    int r, h, k, lo, hi, ar, ai, br, bi, tr, ti, cr, ci;
    for (int n = 0; n < 8; n++) begin
      r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      re[r] = s16(x[n][31:16]);
      im[r] = s16(x[n][15:0]);
    end
    h = 1;
    while (h < 8) begin
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int p = 0; p < h; p++) begin
          k  = p * 4 / h;
          lo = g + p;
          hi = lo + h;
          ar = re[lo]; ai = im[lo]; br = re[hi]; bi = im[hi];
          if (k == 0) begin
            tr = br; ti = bi;
          end else if (k == 2) begin
            tr = bi; ti = -br;
          end else begin
            cr = (k == 1) ? 23170 : -23170;
            ci = -23170;
            tr = (cr * br - ci * bi) >>> 15;
            ti = (cr * bi + ci * br) >>> 15;
          end
          re[lo] = s16(16'((ar + tr) >>> 1));
          im[lo] = s16(16'((ai + ti) >>> 1));
          re[hi] = s16(16'((ar - tr) >>> 1));
          im[hi] = s16(16'((ai - ti) >>> 1));
        end
      end
      h = h * 2;
    end
    for (int i = 0; i < 8; i++) y[i] = {re[i][15:0], im[i][15:0]};
  endfunction

  task automatic load_frame(input frame_t x);
    int n, g;
    logic xfer;
    n = 0;
    g = 0;
    while (n < 8 && g < 64) begin
      i_data_valid = 1'b1;
      i_data       = x[n];
      xfer         = o_data_ready;
      @(posedge i_clk); #1;
      if (xfer) n++;
      g++;
    end
    // Valid stays high with junk data: the block must ignore it outside LOAD.
    i_data = $urandom;
    check("load_count", n, 8);
  endtask

  task automatic wait_compute(input string tag);
    int lat;
    logic rdy_seen;
    lat = 0;
    rdy_seen = 1'b0;
    while (!o_data_valid && lat < 40) begin
      rdy_seen |= o_data_ready;
      i_data = $urandom;
      @(posedge i_clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 12);
    check({tag, "_ready_in_compute"}, rdy_seen, 0);
  endtask

  task automatic unload(input frame_t e, input bit bp, input string tag);
    int idx, cyc;
    logic rdy, prev_rdy, bad;
    logic [31:0] prev_data;
    idx = 0;
    cyc = 0;
    prev_rdy = 1'b1;
    bad = 1'b0;
    prev_data = '0;
    while (idx < 8 && cyc < 64) begin
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      i_data_ready = rdy;
      i_data = $urandom;
      if (!prev_rdy) check($sformatf("%s_hold%0d", tag, idx), o_data, prev_data);
      bad |= o_data_ready | ~o_data_valid;
      if (rdy) check($sformatf("%s_bin%0d", tag, idx), o_data, e[idx]);
      prev_rdy = rdy;
      prev_data = o_data;
      @(posedge i_clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;
    check({tag, "_unload_flags"}, bad, 0);
    check({tag, "_bin_count"}, idx, 8);
    check({tag, "_done_valid"}, o_data_valid, 0);
    check({tag, "_done_ready"}, o_data_ready, 1);
  endtask

  task automatic run_frame(input frame_t x, input frame_t e, input bit bp, input string tag);
    load_frame(x);
    wait_compute(tag);
    unload(e, bp, tag);
  endtask

  initial begin
    frame_t x, e, fx, fe;
    logic [31:0] acc[$];
    logic [31:0] exp_q[$];
    int in_t[$];
    int out_t[$];

    i_rst_n = 1'b0;
    i_data_valid = 1'b0;
    i_data = '0;
    i_data_ready = 1'b1;
    #1;
    check("rst_ready", o_data_ready, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_data", o_data, 0);
    #11 i_rst_n = 1'b1;
    #1 check("release_ready_low", o_data_ready, 0);
    @(posedge i_clk); #1;
    check("release_ready_high", o_data_ready, 1);

    // Impulse, DC and alternating inputs with their exact expected spectra.
    for (int i = 0; i < 8; i++) begin
      x[i] = (i == 0) ? 32'h4000_0000 : 32'h0;
      e[i] = 32'h0800_0000;
    end
    run_frame(x, e, 1'b0, "impulse");
    for (int i = 0; i < 8; i++) begin
      x[i] = 32'h0800_0000;
      e[i] = (i == 0) ? 32'h0800_0000 : 32'h0;
    end
    run_frame(x, e, 1'b0, "dc");
    for (int i = 0; i < 8; i++) begin
      x[i] = (i % 2 == 1) ? 32'hF800_0000 : 32'h0800_0000;
      e[i] = (i == 4) ? 32'h0800_0000 : 32'h0;
    end
    run_frame(x, e, 1'b0, "alt");

    // Random frames, the second one with 1,0,0,1 output backpressure.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) x[i] = $urandom;
      ref_fft(x, e);
      run_frame(x, e, f == 1, $sformatf("rand%0d", f));
    end

    // Reset while a bin is being presented.
    for (int i = 0; i < 8; i++) x[i] = $urandom | 32'h0001_0001;
    load_frame(x);
    wait_compute("rst_unload");
    i_data_ready = 1'b0;
    @(posedge i_clk); #1;
    #1 i_rst_n = 1'b0;
    #1;
    check("rst_unload_valid", o_data_valid, 0);
    check("rst_unload_data", o_data, 0);
    check("rst_unload_ready", o_data_ready, 0);
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("rst_unload_ready_after", o_data_ready, 1);

    // Reset in the fifth compute cycle, then a fresh impulse frame.
    for (int i = 0; i < 8; i++) x[i] = $urandom;
    load_frame(x);
    repeat (4) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_compute_valid", o_data_valid, 0);
    check("rst_compute_data", o_data, 0);
    check("rst_compute_ready", o_data_ready, 0);
    i_data_valid = 1'b0;
    #3 i_rst_n = 1'b1;
    #1 check("rst_compute_ready_low", o_data_ready, 0);
    @(posedge i_clk); #1;
    check("rst_compute_ready_high", o_data_ready, 1);
    for (int i = 0; i < 8; i++) begin
      x[i] = (i == 0) ? 32'h4000_0000 : 32'h0;
      e[i] = 32'h0800_0000;
    end
    run_frame(x, e, 1'b0, "post_rst_impulse");

    // Continuous stream: three back-to-back frames with both handshakes held high.
    i_data_valid = 1'b1;
    i_data_ready = 1'b1;
    for (int t = 0; t < 84; t++) begin
      i_data = 32'h0010_0020 + t;
      if (o_data_ready) begin
        acc.push_back(i_data);
        in_t.push_back(t);
        if (acc.size() == 8) begin
          for (int i = 0; i < 8; i++) fx[i] = acc[i];
          ref_fft(fx, fe);
          for (int i = 0; i < 8; i++) exp_q.push_back(fe[i]);
          acc.delete();
        end
      end
      if (o_data_valid) begin
        out_t.push_back(t);
        if (exp_q.size() == 0) check("stream_spurious_valid", o_data_valid, 0);
        else check($sformatf("stream_bin%0d", out_t.size() - 1), o_data, exp_q.pop_front());
      end
      @(posedge i_clk); #1;
    end
    i_data_valid = 1'b0;
    check("stream_in_count", in_t.size(), 24);
    check("stream_out_count", out_t.size(), 24);
    if (in_t.size() >= 24 && out_t.size() >= 24) begin
      check("stream_in_period", in_t[8] - in_t[0], 28);
      check("stream_in_period2", in_t[16] - in_t[8], 28);
      check("stream_out_period", out_t[8] - out_t[0], 28);
      // Valid rises 12 edges after the 8th input edge; bin 0 transfers on the edge after that.
      check("stream_first_out", out_t[0] - in_t[7], 13);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
